mem_access_unit: RTL and testbench

- Load/store sequencer sitting directly upstream of the word-only data memory. The memory has a combinational read and a synchronous write on clk.
- Converts MIPS byte/halfword/word load and store requests from the CPU execute stage into word-aligned memory accesses.
- Sub-word stores are performed as read-modify-write. Loads are extracted and extended per op.
- Big-endian: byte offset 0 is bits [31:24].

---
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and word-memory bus bundle for mem_access_unit.
// slave: the access unit; master: the requesting CPU stage / memory side.
interface mem_access_unit_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] rt_old;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] load_result;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport slave (
    input  start, op, addr, store_data, rt_old, data_readdata,
    output busy, done, error, load_result,
    output data_address, data_read, data_write, data_writedata
  );

  modport master (
    output start, op, addr, store_data, rt_old, data_readdata,
    input  busy, done, error, load_result,
    input  data_address, data_read, data_write, data_writedata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Big-endian MIPS load/store sequencer in front of a word-only memory.
// Optional macro UNALIGNED_LR_EN enables LWL/LWR; otherwise ops 8/9 are illegal.
module mem_access_unit #(
  parameter int MEM_ADDR_BITS  = 18,
  parameter bit ILLEGAL_READ_X = 1'b0
) (
  input logic           clk,
  input logic           reset,
  mem_access_unit_if.slave bus
);
  localparam logic [3:0] OP_LW = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_SW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7;
`ifdef UNALIGNED_LR_EN
  localparam logic [3:0] OP_LWL = 4'd8, OP_LWR = 4'd9;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, FIN} state_t;
  state_t state, state_n;

  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] sd_q, merge_q, load_q, wd_q, addr_out_q;
  logic        err_q;
`ifdef UNALIGNED_LR_EN
  logic [31:0] rt_q;
`endif

  logic        acc, bad, op_legal, misaligned, out_of_range;
  logic        wr_state, wr_en;
  logic [31:0] ld_val, wd_val, rd_sh, lane_mask, lane_data;

  // Request validation on the live inputs; only consulted in IDLE
  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH: op_legal = 1'b1;
`ifdef UNALIGNED_LR_EN
      OP_LWL, OP_LWR: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
    misaligned = 1'b0;
    case (bus.op)
      OP_LW, OP_SW:         misaligned = (bus.addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = bus.addr[0];
      default:              misaligned = 1'b0;
    endcase
    out_of_range = ((bus.addr >> MEM_ADDR_BITS) != 32'd0);
    bad = !op_legal || misaligned || out_of_range;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    acc     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        acc = 1'b1;
        if (bad)                                  state_n = FIN;
        else if (bus.op == OP_SW)                 state_n = WRITE;
        else if (bus.op == OP_SB || bus.op == OP_SH) state_n = RMW_READ;
        else                                      state_n = LOAD;
      end
      LOAD:      state_n = FIN;
      WRITE:     state_n = FIN;
      RMW_READ:  state_n = RMW_WRITE;
      RMW_WRITE: state_n = FIN;
      FIN:       state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Load extraction: rd_sh right-justifies the addressed byte (offset 0 = MSB)
  always_comb begin
    rd_sh  = bus.data_readdata >> {2'd3 - off_q, 3'b000};
    ld_val = bus.data_readdata;
    case (op_q)
      OP_LB:  ld_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
      OP_LBU: ld_val = {24'd0, rd_sh[7:0]};
      OP_LH:  ld_val = off_q[1] ? {{16{bus.data_readdata[15]}}, bus.data_readdata[15:0]}
                                : {{16{bus.data_readdata[31]}}, bus.data_readdata[31:16]};
      OP_LHU: ld_val = off_q[1] ? {16'd0, bus.data_readdata[15:0]}
                                : {16'd0, bus.data_readdata[31:16]};
`ifdef UNALIGNED_LR_EN
      OP_LWL: ld_val = (bus.data_readdata << {off_q, 3'b000})
                     | (rt_q & ~(32'hFFFF_FFFF << {off_q, 3'b000}));
      OP_LWR: ld_val = rd_sh | (rt_q & ~(32'hFFFF_FFFF >> {2'd3 - off_q, 3'b000}));
`endif
      default: ld_val = bus.data_readdata;
    endcase
  end

  // Store merge: replace the addressed lane of the word read in RMW_READ
  always_comb begin
    if (op_q == OP_SH) begin
      lane_mask = off_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      lane_data = {2{sd_q[15:0]}};
    end else begin
      lane_mask = 32'hFF00_0000 >> {off_q, 3'b000};
      lane_data = {4{sd_q[7:0]}};
    end
    wd_val = (state == WRITE) ? sd_q : ((merge_q & ~lane_mask) | (lane_data & lane_mask));
  end

  assign wr_state = (state == WRITE) || (state == RMW_WRITE);
  // Reset masks the write so a reset landing on a write state cannot corrupt memory
  assign wr_en    = wr_state && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0; off_q <= '0; sd_q <= '0; merge_q <= '0;
      load_q <= '0; wd_q <= '0; addr_out_q <= '0; err_q <= 1'b0;
`ifdef UNALIGNED_LR_EN
      rt_q <= '0;
`endif
    end else begin
      if (acc) begin
        op_q       <= bus.op;
        off_q      <= bus.addr[1:0];
        sd_q       <= bus.store_data;
        addr_out_q <= {bus.addr[31:2], 2'b00};
        err_q      <= bad;
`ifdef UNALIGNED_LR_EN
        rt_q       <= bus.rt_old;
`endif
      end
      if (state == LOAD)     load_q  <= ld_val;
      if (state == RMW_READ) merge_q <= bus.data_readdata;
      if (wr_en)             wd_q    <= wd_val;
    end
  end

  always_comb begin
    if (wr_state)            bus.data_writedata = wd_val;
    else if (ILLEGAL_READ_X) bus.data_writedata = 'x;
    else                     bus.data_writedata = wd_q;
  end

  assign bus.busy         = (state != IDLE) && (state != FIN);
  assign bus.done         = (state == FIN);
  assign bus.error        = (state == FIN) && err_q;
  assign bus.load_result  = load_q;
  assign bus.data_address = addr_out_q;
  assign bus.data_read    = (state == LOAD) || (state == RMW_READ);
  assign bus.data_write   = wr_en;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();
  mem_access_unit #(.MEM_ADDR_BITS(18), .ILLEGAL_READ_X(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [31:0] mem [0:255];
  int wr_seen = 0;
  assign bus.data_readdata = mem[bus.data_address[9:2]];
  always @(posedge clk) begin
    if (bus.data_write) begin
      mem[bus.data_address[9:2]] <= bus.data_writedata;
      wr_seen <= wr_seen + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rt;
    int          lat;
    logic        err;
    logic        chk_res;
    logic [31:0] res;
    int          nrd;
    int          nwr;
    logic        chk_mem;
    int          midx;
    logic [31:0] mval;
  } vec_t;

  vec_t v [$];

  task automatic add(input string name, input logic [3:0] op, input logic [31:0] addr,
                     input logic [31:0] sd, input logic [31:0] rt, input int lat,
                     input logic err, input logic chk_res, input logic [31:0] res,
                     input int nrd, input int nwr, input logic chk_mem,
                     input int midx, input logic [31:0] mval);
    vec_t t;
    t.name = name; t.op = op; t.addr = addr; t.sd = sd; t.rt = rt; t.lat = lat;
    t.err = err; t.chk_res = chk_res; t.res = res; t.nrd = nrd; t.nwr = nwr;
    t.chk_mem = chk_mem; t.midx = midx; t.mval = mval;
    v.push_back(t);
  endtask

  task automatic run(input vec_t t);
    int cyc, nrd, nwr;
    @(negedge clk);
    bus.start = 1'b1; bus.op = t.op; bus.addr = t.addr;
    bus.store_data = t.sd; bus.rt_old = t.rt;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; nrd = 0; nwr = 0;
    while (!bus.done && cyc < 8) begin
      if (cyc == 1) chk({t.name, " data_address"}, bus.data_address, {t.addr[31:2], 2'b00});
      nrd += int'(bus.data_read);
      nwr += int'(bus.data_write);
      @(negedge clk);
      cyc++;
    end
    if (cyc == 1) chk({t.name, " busy"}, {31'd0, bus.busy}, {31'd0, !t.err});
    chk({t.name, " latency"}, cyc, t.lat);
    chk({t.name, " error"}, {31'd0, bus.error}, {31'd0, t.err});
    chk({t.name, " reads"}, nrd, t.nrd);
    chk({t.name, " writes"}, nwr, t.nwr);
    if (t.chk_res) chk({t.name, " load_result"}, bus.load_result, t.res);
    @(negedge clk);
    if (t.chk_mem) chk({t.name, " mem"}, mem[t.midx], t.mval);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.addr = '0; bus.store_data = '0; bus.rt_old = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[4]  = 32'h8899AABB;
    mem[8]  = 32'h11223344;
    mem[12] = 32'hCAFEF00D;

    //   name     op     addr          sd            rt            lat err res  result        rd wr mem idx value
    add("LW",     4'd0, 32'h10,       32'h0,        32'h0,        2, 0, 1, 32'h8899AABB, 1, 0, 0, 0,  32'h0);
    add("LB",     4'd1, 32'h12,       32'h0,        32'h0,        2, 0, 1, 32'hFFFFFFAA, 1, 0, 0, 0,  32'h0);
    add("LBU",    4'd2, 32'h12,       32'h0,        32'h0,        2, 0, 1, 32'h000000AA, 1, 0, 0, 0,  32'h0);
    add("LB1",    4'd1, 32'h11,       32'h0,        32'h0,        2, 0, 1, 32'hFFFFFF99, 1, 0, 0, 0,  32'h0);
    add("LH",     4'd3, 32'h10,       32'h0,        32'h0,        2, 0, 1, 32'hFFFF8899, 1, 0, 0, 0,  32'h0);
    add("LHU",    4'd4, 32'h12,       32'h0,        32'h0,        2, 0, 1, 32'h0000AABB, 1, 0, 0, 0,  32'h0);
    add("SB",     4'd6, 32'h21,       32'hEE,       32'h0,        3, 0, 0, 32'h0,        1, 1, 1, 8,  32'h11EE3344);
    add("SH",     4'd7, 32'h22,       32'h5566,     32'h0,        3, 0, 0, 32'h0,        1, 1, 1, 8,  32'h11EE5566);
    add("SW",     4'd5, 32'h30,       32'h12345678, 32'h0,        2, 0, 0, 32'h0,        0, 1, 1, 12, 32'h12345678);
    add("LW2",    4'd0, 32'h30,       32'h0,        32'h0,        2, 0, 1, 32'h12345678, 1, 0, 0, 0,  32'h0);
    add("misal",  4'd0, 32'h22,       32'h0,        32'h0,        1, 1, 0, 32'h0,        0, 0, 0, 0,  32'h0);
    add("range",  4'd0, 32'h00040000, 32'h0,        32'h0,        1, 1, 0, 32'h0,        0, 0, 0, 0,  32'h0);
    add("illop",  4'hF, 32'h10,       32'h0,        32'h0,        1, 1, 0, 32'h0,        0, 0, 0, 0,  32'h0);
    add("SHmis",  4'd7, 32'h21,       32'h0,        32'h0,        1, 1, 0, 32'h0,        0, 0, 1, 8,  32'h11EE5566);
`ifdef UNALIGNED_LR_EN
    add("LWL",    4'd8, 32'h11,       32'h0,        32'h01020304, 2, 0, 1, 32'h99AABB04, 1, 0, 0, 0,  32'h0);
    add("LWR",    4'd9, 32'h12,       32'h0,        32'h01020304, 2, 0, 1, 32'h018899AA, 1, 0, 0, 0,  32'h0);
`else
    add("LWL",    4'd8, 32'h11,       32'h0,        32'h01020304, 1, 1, 0, 32'h0,        0, 0, 0, 0,  32'h0);
    add("LWR",    4'd9, 32'h12,       32'h0,        32'h01020304, 1, 1, 0, 32'h0,        0, 0, 0, 0,  32'h0);
`endif

    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset addr", bus.data_address, 32'd0);
    chk("reset wdata", bus.data_writedata, 32'd0);
    reset = 1'b0;

    foreach (v[i]) run(v[i]);

    // start while busy must be dropped, not queued
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd0; bus.addr = 32'h10;
    @(negedge clk);
    bus.op = 4'd5; bus.store_data = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ignore done", {31'd0, bus.done}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ignore no done", {31'd0, bus.done | bus.busy}, 32'd0);
    end
    chk("ignore mem", mem[4], 32'h8899AABB);

    // reset for 2 cycles while SB sits in RMW_READ
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd6; bus.addr = 32'h21; bus.store_data = 32'h77;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst mid busy", {31'd0, bus.busy}, 32'd1);
    begin
      int base;
      base = wr_seen;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst busy", {31'd0, bus.busy}, 32'd0);
      chk("rst done", {31'd0, bus.done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("rst idle", {31'd0, bus.busy | bus.done}, 32'd0);
      chk("rst no write", wr_seen, base);
      chk("rst mem", mem[8], 32'h11EE5566);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
